// File: rtl/eq2_sweep_checker.sv
// Sweep sequencer for a W-bit equality comparator: drives every {x,y} pair,
// waits SETTLE cycles, samples eq_in and tallies mismatches.
module eq2_sweep_checker #(
  parameter int W      = 2,
  parameter int SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [W-1:0]   x_out,
  output logic [W-1:0]   y_out,
  input  logic           eq_in,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   err_count,
  output logic [2*W-1:0] first_fail,
  output logic           first_fail_valid
);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0]     WAIT_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam logic [2*W-1:0] LAST_VEC  = '1;
  localparam logic [2*W-1:0] VEC_ONE   = {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [2*W:0]   ERR_ONE   = {{(2*W){1'b0}}, 1'b1};

  state_t         state;
  logic [2*W-1:0] v;
  logic [3:0]     wait_cnt;
  logic           expected;
  logic           mismatch;

  assign x_out    = v[2*W-1:W];
  assign y_out    = v[W-1:0];
  assign expected = (v[2*W-1:W] == v[W-1:0]);
  assign mismatch = (eq_in != expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      v                <= '0;
      wait_cnt         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            v                <= '0;
            err_count        <= '0;
            pass             <= 1'b0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            busy             <= 1'b1;
            state            <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          wait_cnt <= WAIT_LOAD;
          state    <= (SETTLE > 0) ? S_WAIT : S_SAMPLE;
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_SAMPLE;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_SAMPLE: begin
          // first_fail is latched once per sweep; later mismatches only count
          if (mismatch) begin
            err_count <= err_count + ERR_ONE;
            if (!first_fail_valid) begin
              first_fail       <= v;
              first_fail_valid <= 1'b1;
            end
          end
          if (v == LAST_VEC) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            v     <= v + VEC_ONE;
            state <= S_DRIVE;
          end
        end
        S_DONE: begin
          pass  <= (err_count == '0);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eq2_sweep_checker.sv
// Bench: two checkers (SETTLE=2 and SETTLE=0) driving modelled comparators,
// results compared against a per-vector timeline model of the sweep.
module tb_eq2_sweep_checker;

  localparam int N  = 16;
  localparam int PA = 4;
  localparam int PB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, startA, startB, eqA, eqB;
  logic [1:0] xA, yA, xB, yB;
  logic       busyA, doneA, passA, ffvA, busyB, doneB, passB, ffvB;
  logic [4:0] errA, errB;
  logic [3:0] ffA, ffB;

  int          mode = 0;
  logic [15:0] faultMask = '0;
  logic [2:0]  pipeA = '0, pipeB = '0;
  int          testsRun = 0, testsFailed = 0;
  int          heldA = 0, heldB = 0;

  eq2_sweep_checker #(.W(2), .SETTLE(2)) dutA (
    .clk(clk), .rst(rst), .start(startA), .x_out(xA), .y_out(yA), .eq_in(eqA),
    .busy(busyA), .done(doneA), .pass(passA), .err_count(errA),
    .first_fail(ffA), .first_fail_valid(ffvA));

  eq2_sweep_checker #(.W(2), .SETTLE(0)) dutB (
    .clk(clk), .rst(rst), .start(startB), .x_out(xB), .y_out(yB), .eq_in(eqB),
    .busy(busyB), .done(doneB), .pass(passB), .err_count(errB),
    .first_fail(ffB), .first_fail_valid(ffvB));

  // Comparator models: ideal, stuck-0, inverted, broken at (2,2), 3-cycle delay, random faults
  function automatic logic compModel(int m, logic [3:0] vec, logic delayed, logic [15:0] mask);
    logic ideal;
    ideal = (vec[3:2] == vec[1:0]);
    case (m)
      1:       return 1'b0;
      2:       return !ideal;
      3:       return (vec == 4'b1010) ? 1'b0 : ideal;
      4:       return delayed;
      5:       return ideal ^ mask[vec];
      default: return ideal;
    endcase
  endfunction

  always_comb begin
    eqA = compModel(mode, {xA, yA}, pipeA[2], faultMask);
    eqB = compModel(mode, {xB, yB}, pipeB[2], faultMask);
  end

  always @(posedge clk) begin
    pipeA <= {pipeA[1:0], xA == yA};
    pipeB <= {pipeB[1:0], xB == yB};
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: vector shown in relative cycle c is (c-1)/p for c>=1, else the held vector
  task automatic refSweep(input int m, input int p, input int held, input logic [15:0] mask,
                          output int errs, output int first, output int valid);
    int s, c, vec, xv, yv, obs, exp;
    errs = 0; first = 0; valid = 0;
    for (int n = 0; n < N; n++) begin
      s   = (n + 1) * p;
      c   = (m == 4) ? s - 3 : s;
      vec = (c >= 1) ? (c - 1) / p : held;
      xv  = vec / 4;
      yv  = vec % 4;
      case (m)
        1:       obs = 0;
        2:       obs = (xv != yv) ? 1 : 0;
        3:       obs = (xv == 2 && yv == 2) ? 0 : ((xv == yv) ? 1 : 0);
        5:       obs = ((xv == yv) ? 1 : 0) ^ int'(mask[vec]);
        default: obs = (xv == yv) ? 1 : 0;
      endcase
      exp = ((n / 4) == (n % 4)) ? 1 : 0;
      if (obs != exp) begin
        errs++;
        if (valid == 0) begin
          first = n;
          valid = 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input int m, input int repulse, input int rstAt);
    int busyCntA = 0, firstBusyA = 0, lastBusyA = 0, doneCntA = 0, doneCycA = 0, vecErrA = 0;
    int doneCntB = 0, doneCycB = 0, vecErrB = 0;
    int errs, first, valid;
    string tg;
    tg = $sformatf("m%0d", m);
    mode = m;
    if (m == 5) faultMask = 16'($urandom);
    repeat ($urandom_range(3, 8)) @(negedge clk);
    startA = 1'b1; startB = 1'b1;
    @(negedge clk);
    startA = 1'b0; startB = 1'b0;
    for (int c = 1; c <= N * PA + 2; c++) begin
      if (busyA) begin
        busyCntA++;
        if (firstBusyA == 0) firstBusyA = c;
        lastBusyA = c;
      end
      if (doneA) begin doneCntA++; doneCycA = c; end
      if (doneB) begin doneCntB++; doneCycB = c; end
      if (c <= N * PA && (rstAt == 0 || c <= rstAt) && int'({xA, yA}) != (c - 1) / PA) vecErrA++;
      if (c <= N * PB && (rstAt == 0 || c <= rstAt) && int'({xB, yB}) != (c - 1) / PB) vecErrB++;
      if (c == 1) begin
        checkOutput({tg, "_passA_cleared"}, passA, 0);
        checkOutput({tg, "_passB_cleared"}, passB, 0);
      end
      startA = (repulse != 0 && (c == 10 || c == N * PA + 1));
      if (rstAt != 0 && c == rstAt) rst = 1'b1;
      if (rstAt != 0 && c == rstAt + 1) begin
        checkOutput("rst_busyA", busyA, 0);
        checkOutput("rst_xA", xA, 0);
        checkOutput("rst_yA", yA, 0);
        checkOutput("rst_errA", errA, 0);
        checkOutput("rst_busyB", busyB, 0);
        checkOutput("rst_xB", xB, 0);
        rst = 1'b0;
      end
      if (c < N * PA + 2) @(negedge clk);
    end
    checkOutput({tg, "_vecA"}, vecErrA, 0);
    checkOutput({tg, "_vecB"}, vecErrB, 0);
    if (rstAt == 0) begin
      checkOutput({tg, "_busy_first"}, firstBusyA, 1);
      checkOutput({tg, "_busy_last"}, lastBusyA, N * PA);
      checkOutput({tg, "_busy_cnt"}, busyCntA, N * PA);
      checkOutput({tg, "_done_cyc"}, doneCycA, N * PA + 1);
      checkOutput({tg, "_done_cnt"}, doneCntA, 1);
      refSweep(m, PA, heldA, faultMask, errs, first, valid);
      checkOutput({tg, "_errA"}, errA, errs);
      checkOutput({tg, "_ffA"}, ffA, first);
      checkOutput({tg, "_ffvA"}, ffvA, valid);
      checkOutput({tg, "_passA"}, passA, (errs == 0) ? 1 : 0);
      checkOutput({tg, "_done_cycB"}, doneCycB, N * PB + 1);
      checkOutput({tg, "_done_cntB"}, doneCntB, 1);
      refSweep(m, PB, heldB, faultMask, errs, first, valid);
      checkOutput({tg, "_errB"}, errB, errs);
      checkOutput({tg, "_ffB"}, ffB, first);
      checkOutput({tg, "_ffvB"}, ffvB, valid);
      checkOutput({tg, "_passB"}, passB, (errs == 0) ? 1 : 0);
      heldA = N - 1;
      heldB = N - 1;
    end else begin
      checkOutput("rst_busy_cnt", busyCntA, rstAt);
      checkOutput("rst_no_doneA", doneCntA, 0);
      checkOutput("rst_no_doneB", doneCntB, 0);
      checkOutput("rst_errA_after", errA, 0);
      checkOutput("rst_ffvA_after", ffvA, 0);
      heldA = 0;
      heldB = 0;
    end
  endtask

  initial begin
    rst = 1'b1; startA = 1'b0; startB = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busyA, 0);
    checkOutput("reset_done", doneA, 0);
    checkOutput("reset_pass", passA, 0);
    checkOutput("reset_err", errA, 0);
    checkOutput("reset_ff", ffA, 0);
    checkOutput("reset_ffv", ffvA, 0);
    checkOutput("reset_xy", {xA, yA}, 0);
    checkOutput("reset_busyB", busyB, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(2, 0, 0);
    applyStimulus(3, 0, 0);
    applyStimulus(4, 0, 0);
    applyStimulus(1, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(5, 0, 0);
    applyStimulus(0, 0, 20);
    applyStimulus(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
